// File: rtl/fetch_ctrl_pkg.sv
// Shared ISA encodings, FSM states and program address tables
// for the instruction-ROM sequencer.
package fetch_ctrl_pkg;

  localparam int ROM_AW = 9;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_CMP  = 5'b00100,
    OP_LD   = 5'b00101,
    OP_ST   = 5'b00110,
    OP_BE   = 5'b00111,
    OP_BL   = 5'b01000,
    OP_BG   = 5'b01001,
    OP_BA   = 5'b01010,
    OP_MOV  = 5'b01011,
    OP_LDI  = 5'b01100,
    OP_NOP  = 5'b01101,
    OP_DONE = 5'b01110
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PROG_PRODUCT = 2'd0,
    PROG_STRING  = 2'd1,
    PROG_CLOSEST = 2'd2,
    PROG_RSVD    = 2'd3
  } prog_e;

  function automatic logic [ROM_AW-1:0] start_pc(
    input logic [1:0] sel
  );
    logic [ROM_AW-1:0] pc;
    case (sel)
      2'd0:    pc = 9'h001;
      2'd1:    pc = 9'h019;
      default: pc = 9'h02A;
    endcase
    return pc;
  endfunction

  function automatic logic [ROM_AW-1:0] end_pc(
    input logic [1:0] sel
  );
    logic [ROM_AW-1:0] pc;
    case (sel)
      2'd0:    pc = 9'h018;
      2'd1:    pc = 9'h029;
      default: pc = 9'h03B;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Start/Ack handshake, ROM fetch and datapath flag bundle
// between the top level and the sequencer.
interface fetch_ctrl_if #(
  parameter int PC_W  = 9,
  parameter int CYC_W = 12
);

  logic             Start;
  logic [1:0]       prog_sel;
  logic [19:0]      inst;
  logic             stall;
  logic             flag_eq;
  logic             flag_lt;
  logic             flag_gt;
  logic [PC_W-1:0]  iptr;
  logic             commit;
  logic             Ack;
  logic             timeout;
  logic [CYC_W-1:0] cycles;

  modport master (
    output Start, prog_sel, inst, stall,
    output flag_eq, flag_lt, flag_gt,
    input  iptr, commit, Ack, timeout, cycles
  );

  modport slave (
    input  Start, prog_sel, inst, stall,
    input  flag_eq, flag_lt, flag_gt,
    output iptr, commit, Ack, timeout, cycles
  );

endinterface

// File: rtl/fetch_ctrl_branch_unit.sv
// Next-PC resolution: conditional/unconditional relative
// branches from the flags, otherwise sequential fetch.
module branch_unit
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic [4:0]      i_op,
  input  logic [14:0]     i_off,
  input  logic            i_eq,
  input  logic            i_lt,
  input  logic            i_gt,
  input  logic [PC_W-1:0] i_pc,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_is_done
);

  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_tgt;
  logic            w_take;
  logic            w_unused_off;

  // Upper offset bits vanish under the mod-2^PC_W wrap.
  assign w_unused_off = ^i_off[14:PC_W];

  assign w_seq = i_pc + PC_W'(1);
  assign w_tgt = i_pc + i_off[PC_W-1:0];

  always_comb begin
    w_take = 1'b0;
    unique case (1'b1)
      (i_op == OP_BE): w_take = i_eq;
      (i_op == OP_BL): w_take = i_lt;
      (i_op == OP_BG): w_take = i_gt;
      (i_op == OP_BA): w_take = 1'b1;
      default:         w_take = 1'b0;
    endcase
  end

  assign o_next_pc = w_take ? w_tgt : w_seq;
  assign o_is_done = (i_op == OP_DONE);

endmodule

// File: rtl/fetch_ctrl.sv
// Program sequencer: PC, program select, branch resolution,
// watchdog and Start/Ack handshake for the instruction ROM.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int MAX_CYC = 4095,
  parameter int CYC_W   = 12
) (
  input logic         Clk,
  input logic         Reset,
  fetch_ctrl_if.slave bus
);

  state_e           r_state;
  state_e           w_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [CYC_W-1:0] r_cycles;
  logic [1:0]       r_sel;
  logic             r_timeout;

  logic [4:0]       w_op;
  logic [PC_W-1:0]  w_next_pc;
  logic             w_is_done;
  logic             w_go;
  logic             w_end_hit;
  logic             w_fin;
  logic             w_wd;

  assign w_op = bus.inst[19:15];

  branch_unit #(
    .PC_W (PC_W)
  ) u_br (
    .i_op      (w_op),
    .i_off     (bus.inst[14:0]),
    .i_eq      (bus.flag_eq),
    .i_lt      (bus.flag_lt),
    .i_gt      (bus.flag_gt),
    .i_pc      (r_pc),
    .o_next_pc (w_next_pc),
    .o_is_done (w_is_done)
  );

  assign w_go = bus.Start &&
    (prog_e'(bus.prog_sel) != PROG_RSVD);

  assign w_end_hit = !bus.stall &&
    (r_pc == PC_W'(end_pc(r_sel)));

  // A normal finish masks a watchdog hit in the same cycle.
  assign w_fin = (w_is_done && !bus.stall) || w_end_hit;
  assign w_wd  = (r_cycles == CYC_W'(MAX_CYC - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_go)           w_nxt = ST_RUN;
      ST_RUN:  if (w_fin || w_wd)  w_nxt = ST_HALT;
      ST_HALT: if (!bus.Start)     w_nxt = ST_IDLE;
      default:                     w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc      <= '0;
      r_cycles  <= '0;
      r_sel     <= '0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_pc      <= PC_W'(start_pc(bus.prog_sel));
            r_cycles  <= '0;
            r_sel     <= bus.prog_sel;
            r_timeout <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cycles <= r_cycles + CYC_W'(1);
          if (w_wd && !w_fin)
            r_timeout <= 1'b1;
          if (!bus.stall && !w_fin && !w_wd)
            r_pc <= w_next_pc;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.commit = 1'b0;
    if (r_state == ST_RUN)
      bus.commit = !bus.stall && !w_is_done;
  end

  assign bus.Ack     = (r_state == ST_HALT);
  assign bus.iptr    = r_pc;
  assign bus.timeout = r_timeout;
  assign bus.cycles  = r_cycles;

endmodule
